me_sequencer: RTL and testbench

//  Control/address sequencer for the 16-PE systolic full-search motion estimator (16x16 ref block, 31x31 window).

---
 rtl/me_sequencer.sv | 175 +++++++++++++++++
 tb/tb_me_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/me_sequencer.sv
// me_sequencer: schedule/address generator for the 16-PE systolic full-search
// motion estimator (16x16 reference block, 31x31 search window).
// One cycle counter t walks {vy, r, c} and then 15 drain cycles. Every
// address and strobe is decoded combinationally from the registered t, so
// memories with asynchronous reads see zero latency.
// Optional build macro: ME_STALL_EN adds a stall input that freezes t.

// Per-PE decode. PE J works on reference index k = t - J.
module me_seq_lane #(
  parameter int J     = 0,
  parameter int CNT_W = 13
) (
  input  logic [CNT_W-1:0] t,
  input  logic             run,
  input  logic             main,
  input  logic [3:0]       c,
  output logic             mux,
  output logic             nd,
  output logic             rdy
);
  localparam logic [CNT_W-1:0] JV      = CNT_W'(J);
  localparam logic [CNT_W-1:0] K_DRAIN = CNT_W'(4096);
  localparam logic [CNT_W-1:0] K_ROW   = CNT_W'(256);

  logic [CNT_W-1:0] k;
  logic             started;

  assign k       = t - JV;
  assign started = (t >= JV);

  // PE J takes the S1 port while its column index has been reached in this row.
  assign mux = run & main & (c >= 4'(J));
  // A new candidate starts every 256 reference indices of this PE.
  assign nd  = run & started & (k < K_DRAIN) & (k[7:0] == 8'd0);
  // The previous candidate's SAD is complete once one full block has passed.
  assign rdy = run & started & (k >= K_ROW) & (k[7:0] == 8'd0);
endmodule

module me_sequencer #(
  parameter int SW_STRIDE = 31,
  parameter int CNT_W     = 13
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
`ifdef ME_STALL_EN
  input  logic        stall,
`endif
  output logic [7:0]  AddressR,
  output logic [9:0]  AddressS1,
  output logic [9:0]  AddressS2,
  output logic [15:0] S1S2mux,
  output logic [15:0] NewDist,
  output logic [15:0] PEready,
  output logic        CompStart,
  output logic [3:0]  VectorX,
  output logic [3:0]  VectorY,
  output logic        busy,
  output logic        done
);
  localparam int NUM_LANES = 16;
  localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(4111);
  localparam logic [CNT_W-1:0] T_DRAIN = CNT_W'(4096);
  localparam logic [CNT_W-1:0] T_CMP   = CNT_W'(256);
  localparam logic [9:0]       STRIDE  = 10'(SW_STRIDE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] t;
  logic             advance;
  logic             run;
  logic             main;
  logic [3:0]       vy, r, c;
  logic [9:0]       vy10, r10, c10, srow;
  logic             s2_unused;

`ifdef ME_STALL_EN
  assign advance = ~stall;
`else
  assign advance = 1'b1;
`endif

  // Control FSM: owns the cycle counter and the registered busy/done flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      t     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          t     <= '0;
          busy  <= 1'b1;
        end
        RUN: if (advance) begin
          if (t == T_LAST) begin
            state <= DONE;
            t     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            t <= t + 1'b1;
          end
        end
        DONE: if (!start) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          t     <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign run  = (state == RUN);
  assign main = (t < T_DRAIN);
  assign vy   = t[11:8];
  assign r    = t[7:4];
  assign c    = t[3:0];
  assign vy10 = {6'd0, vy};
  assign r10  = {6'd0, r};
  assign c10  = {6'd0, c};

  // S2 serves the second half of each window row: previous search row, or the
  // tail of the previous vy band when a new reference row 0 starts.
  assign srow      = (r != 4'd0) ? (vy10 + r10 - 10'd1) : (vy10 + 10'd14);
  assign s2_unused = ((vy == 4'd0) && (r == 4'd0)) || (c == 4'd15);

  // Memory addresses, forced to 0 outside the main phase.
  always_comb begin
    AddressR  = '0;
    AddressS1 = '0;
    AddressS2 = '0;
    if (run && main) begin
      AddressR  = t[7:0];
      AddressS1 = (vy10 + r10) * STRIDE + c10;
      AddressS2 = s2_unused ? 10'd0 : (srow * STRIDE + c10 + 10'd16);
    end
  end

  genvar j;
  generate
    for (j = 0; j < NUM_LANES; j++) begin : g_lane
      me_seq_lane #(.J(j), .CNT_W(CNT_W)) u_lane (
        .t    (t),
        .run  (run),
        .main (main),
        .c    (c),
        .mux  (S1S2mux[j]),
        .nd   (NewDist[j]),
        .rdy  (PEready[j])
      );
    end
  endgenerate

  // Candidate vector of the PE reporting this cycle: x is the PE index,
  // y is the vy band that just finished (wraps to 15 in the drain phase).
  always_comb begin
    VectorX = '0;
    VectorY = '0;
    if (|PEready) begin
      VectorX = t[3:0];
      VectorY = t[11:8] - 4'd1;
    end
  end

  assign CompStart = run & (t >= T_CMP);
endmodule

// File: tb/tb_me_sequencer.sv
// tb_me_sequencer: randomized directed run of me_sequencer against a
// candidate-level reference model (vy/r/c arithmetic per PE, no RTL encoding).
module tb_me_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic [7:0]  AddressR;
  logic [9:0]  AddressS1, AddressS2;
  logic [15:0] S1S2mux, NewDist, PEready;
  logic        CompStart;
  logic [3:0]  VectorX, VectorY;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0 idle, 1 run, 2 done
  int mt     = 0;   // model cycle counter

  typedef struct {
    logic [7:0]  ar;
    logic [9:0]  s1, s2;
    logic [15:0] mux, nd, rdy;
    logic        cs;
    logic [3:0]  vx, vy;
    logic        busy, done;
  } exp_t;

  always #5 clock = ~clock;

  me_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
`ifdef ME_STALL_EN
    .stall     (stall),
`endif
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .S1S2mux   (S1S2mux),
    .NewDist   (NewDist),
    .PEready   (PEready),
    .CompStart (CompStart),
    .VectorX   (VectorX),
    .VectorY   (VectorY),
    .busy      (busy),
    .done      (done)
  );

  function automatic exp_t model(int md, int t);
    exp_t e;
    int vy, r, c, k, srow;
    e = '{default: '0};
    e.busy = (md == 1);
    e.done = (md == 2);
    if (md != 1) return e;
    e.cs = (t >= 256);
    if (t < 4096) begin
      vy = t / 256; r = (t / 16) % 16; c = t % 16;
      e.ar = 8'(t % 256);
      e.s1 = 10'((vy + r) * 31 + c);
      if ((vy == 0 && r == 0) || c == 15) e.s2 = '0;
      else begin
        srow = (r > 0) ? vy + r - 1 : vy + 14;
        e.s2 = 10'(srow * 31 + c + 16);
      end
      for (int j = 0; j < 16; j++) e.mux[j] = (j <= c);
    end
    for (int j = 0; j < 16; j++) begin
      k = t - j;
      if (k >= 0 && k < 4096 && k % 256 == 0) e.nd[j] = 1'b1;
      if (k >= 256 && k % 256 == 0) begin
        e.rdy[j] = 1'b1;
        e.vx = 4'(j);
        e.vy = 4'(k / 256 - 1);
      end
    end
    return e;
  endfunction

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, mt, obs, expv);
    end
  endtask

  task automatic check_all();
    exp_t e;
    e = model(mode, mt);
    cmp("AddressR",  32'(AddressR),  32'(e.ar));
    cmp("AddressS1", 32'(AddressS1), 32'(e.s1));
    cmp("AddressS2", 32'(AddressS2), 32'(e.s2));
    cmp("S1S2mux",   32'(S1S2mux),   32'(e.mux));
    cmp("NewDist",   32'(NewDist),   32'(e.nd));
    cmp("PEready",   32'(PEready),   32'(e.rdy));
    cmp("CompStart", 32'(CompStart), 32'(e.cs));
    cmp("VectorX",   32'(VectorX),   32'(e.vx));
    cmp("VectorY",   32'(VectorY),   32'(e.vy));
    cmp("busy",      32'(busy),      32'(e.busy));
    cmp("done",      32'(done),      32'(e.done));
    if (mode == 1) begin
      case (mt)
        0: begin
          cmp("t0_mux", 32'(S1S2mux), 32'h0001);
          cmp("t0_nd",  32'(NewDist), 32'h0001);
          cmp("t0_cs",  32'(CompStart), 32'd0);
        end
        17: begin
          cmp("t17_ar", 32'(AddressR),  32'd17);
          cmp("t17_s1", 32'(AddressS1), 32'd32);
          cmp("t17_s2", 32'(AddressS2), 32'd17);
          cmp("t17_mux", 32'(S1S2mux),  32'h0003);
          cmp("t17_nd", 32'(NewDist),   32'd0);
        end
        256: begin
          cmp("t256_s1",  32'(AddressS1), 32'd31);
          cmp("t256_s2",  32'(AddressS2), 32'd481);
          cmp("t256_rdy", 32'(PEready),   32'h0001);
          cmp("t256_cs",  32'(CompStart), 32'd1);
          cmp("t256_nd",  32'(NewDist),   32'h0001);
        end
        4111: begin
          cmp("t4111_rdy", 32'(PEready), 32'h8000);
          cmp("t4111_vx",  32'(VectorX), 32'd15);
          cmp("t4111_vy",  32'(VectorY), 32'd15);
          cmp("t4111_ar",  32'(AddressR), 32'd0);
        end
        default: ;
      endcase
    end
  endtask

  // Advance the model with the inputs applied for this edge, then compare.
  task automatic tick();
    if (reset) begin
      mode = 0; mt = 0;
    end else begin
      case (mode)
        0: if (start) begin mode = 1; mt = 0; end
        1: begin
`ifdef ME_STALL_EN
          if (!stall) begin
`endif
            if (mt == 4111) mode = 2;
            else mt++;
`ifdef ME_STALL_EN
          end
`endif
        end
        default: if (!start) mode = 0;
      endcase
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    int guard, n, run_cycles;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    #2;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();

    // Full run with random idle lead-in and start toggling during RUN.
    repeat ($urandom_range(0, 5)) tick();
    start = 1'b1;
    tick();
    guard = 0;
    while (mode == 1 && guard < 5000) begin
      start = 1'($urandom_range(0, 1));
`ifdef ME_STALL_EN
      stall = (mt == 300 && guard < 400) ? 1'b1 : 1'b0;
      if (stall) begin
        repeat (5) tick();
        stall = 1'b0;
      end
`endif
      tick();
      guard++;
    end
    cmp("run_len_bound", 32'(guard < 5000), 32'd1);
    cmp("done_after_run", 32'(done), 32'd1);

    // start held high in DONE: no re-run.
    start = 1'b1;
    repeat ($urandom_range(1, 4)) tick();
    cmp("done_hold", 32'(done), 32'd1);
    start = 1'b0;
    tick();
    cmp("back_idle", 32'(busy | done), 32'd0);

    // Reset at t=1000, then restart.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1000) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();

    // Random-length partial run, reset at a random point.
    start = 1'b0;
    run_cycles = $urandom_range(1, 3000);
    for (n = 0; n < run_cycles; n++) begin
      start = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
